// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - two-requester round-robin write arbiter for a shared FIFO
//
// Purpose: grants one of two level-sensitive write requesters access to a
// shared FIFO. Each grant is a fixed IDLE -> WRITE -> GAP sequence, so the
// FIFO strobe is a single-cycle pulse with a guaranteed low cycle after it.
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous, active-low reset
//   req0/data0     requester 0 request level and write data
//   ack0           one-cycle pulse in the cycle requester 0's word is written
//   req1/data1     requester 1 request level and write data
//   ack1           one-cycle pulse in the cycle requester 1's word is written
//   fifo_full      full flag from the shared FIFO (consulted in IDLE only)
//   fifo_write_en  FIFO write strobe (FIFO captures on its 0->1 transition)
//   fifo_data_in   FIFO write data, held between writes
//   grant_id       index of the most recently granted requester
//   busy           high in WRITE and GAP

module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [DATA_WIDTH-1:0] data0,
  output logic                  ack0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic                  ack1,
  input  logic                  fifo_full,
  output logic                  fifo_write_en,
  output logic [DATA_WIDTH-1:0] fifo_data_in,
  output logic                  grant_id,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                  state;
  logic                    last_grant;
  logic                    grant_sel;
  logic [DATA_WIDTH-1:0]   grant_data;

  // Round-robin pick: under contention the requester that did not win last
  // time goes next; a lone requester always wins.
  always_comb begin
    grant_sel = 1'b0;
    if (req0 && req1) begin
      grant_sel = ~last_grant;
    end else if (req1) begin
      grant_sel = 1'b1;
    end
    grant_data = grant_sel ? data1 : data0;
  end

  // fifo_data_in doubles as the hold register: it is loaded only at grant
  // time, so it presents the granted word during WRITE and keeps it after.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      fifo_write_en <= 1'b0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      busy          <= 1'b0;
      fifo_data_in  <= '0;
      grant_id      <= 1'b1;
      last_grant    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if ((req0 || req1) && !fifo_full) begin
            state         <= WRITE;
            fifo_write_en <= 1'b1;
            fifo_data_in  <= grant_data;
            ack0          <= ~grant_sel;
            ack1          <= grant_sel;
            grant_id      <= grant_sel;
            last_grant    <= grant_sel;
            busy          <= 1'b1;
          end
        end
        WRITE: begin
          // Strobe and ack last exactly one cycle.
          state         <= GAP;
          fifo_write_en <= 1'b0;
          ack0          <= 1'b0;
          ack1          <= 1'b0;
        end
        GAP: begin
          // Low strobe cycle for the FIFO edge detector; fifo_full settles
          // here before IDLE looks at it again.
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          fifo_write_en <= 1'b0;
          ack0          <= 1'b0;
          ack1          <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the requester and FIFO data buses.
REQ-002 clock  input  1  single clock; all logic is on the rising edge.
REQ-003 reset  input  1  reset, synchronous and active-low.
REQ-004 req0  input  1  requester 0 write request; level, held until ack0.
REQ-005 data0  input  DATA_WIDTH  requester 0 write data; stable while req0 is high.
REQ-006 ack0  output  1  one-cycle pulse marking the cycle requester 0's word is written.
REQ-007 req1  input  1  requester 1 write request; level, held until ack1.
REQ-008 data1  input  DATA_WIDTH  requester 1 write data; stable while req1 is high.
REQ-009 ack1  output  1  one-cycle pulse marking the cycle requester 1's word is written.
REQ-010 fifo_full  input  1  full flag from the shared FIFO.
REQ-011 fifo_write_en  output  1  FIFO write strobe; the FIFO writes on a 0->1 transition.
REQ-012 fifo_data_in  output  DATA_WIDTH  FIFO write data.
REQ-013 grant_id  output  1  index of the most recently granted requester.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The arbiter SHALL be a three-state FSM: IDLE, WRITE, GAP. All outputs are registered.
REQ-016 IDLE -> WRITE SHALL occur only when (req0|req1) and fifo_full==0. Otherwise the FSM stays in IDLE.
REQ-017 Requests SHALL be sampled only in IDLE; req changes in WRITE/GAP have no effect.
REQ-018 Single request: that requester is granted.
REQ-019 Both requests: the requester not equal to last_grant is granted (round-robin).
REQ-020 On grant, the granted data SHALL be latched into a hold register, and last_grant and grant_id SHALL be updated.
REQ-021 WRITE state, exactly one cycle:
- fifo_write_en=1
- fifo_data_in = held data
- ack of the granted requester = 1
- next state is GAP
REQ-022 GAP state, exactly one cycle:
- fifo_write_en=0, so the FIFO edge detector sees a low cycle
- fifo_full is allowed to settle after the write
- next state is IDLE
REQ-023 fifo_write_en SHALL never be high in two consecutive cycles.
REQ-024 Latency: req rising in IDLE (FIFO not full) -> fifo_write_en and ack high on the next cycle.
REQ-025 Maximum throughput SHALL be one write per 3 cycles.
REQ-026 A requester SHALL drop req by the cycle after its ack (GAP). A req still high when IDLE is re-entered is a new request.
REQ-027 fifo_full is checked in IDLE only. A full FIFO stalls grants indefinitely without losing or reordering pending requests.
REQ-028 ack0 and ack1 SHALL never be high in the same cycle.
REQ-029 fifo_data_in SHALL hold its last value outside WRITE.

Reset
REQ-030 While reset==0 at a rising edge, the following SHALL be set:
- state = IDLE
- fifo_write_en, ack0, ack1, busy = 0
- fifo_data_in = 0
- grant_id = 1
- last_grant = 1, so requester 0 wins the first contention
REQ-031 Reset asserted in WRITE or GAP SHALL abort the cycle: fifo_write_en=0 at the next edge, and no ack is issued for the aborted grant.
REQ-032 The first fifo_write_en pulse after reset release SHALL occur no earlier than the second cycle after release.

Verification
REQ-033 Single request: req0=1, data0=0xA5, FIFO not full -> next cycle fifo_write_en=1, fifo_data_in=0xA5, ack0=1, grant_id=0; then one GAP cycle; then IDLE.
REQ-034 Contention after reset: req0=req1=1 held, data0=0x11, data1=0x22 -> FIFO receives 0x11, then 0x22, then 0x11, alternating; write pulses are 3 cycles apart.
REQ-035 Full stall: fifo_full=1, req1=1 for 10 cycles -> no fifo_write_en, no ack1, busy=0; fifo_full drops -> write of data1 on the next cycle.
REQ-036 Fill to full: drive 17 req0 words into a DEPTH=16 FIFO -> 16 acks; the 17th stalls until a read frees a slot; no fifo_write_en while full.
REQ-037 Reset mid-WRITE: reset=0 in the WRITE cycle -> next cycle fifo_write_en=0 and busy=0; no further ack for that grant.
REQ-038 Protocol checker on all runs:
- no back-to-back fifo_write_en
- ack0 and ack1 never high together
- ack count equals FIFO write count
